lieat_axi_slave_sram: RTL and testbench
=======================================

Name: lieat_axi_slave_sram

Overview:
- AXI4 responder that models an on-chip SRAM and is the slave end of the core's AXI master port (io_master_*).
- Accepts AR/AW requests with IDs, single-beat or INCR/FIXED bursts, byte-strobed writes, and echoes IDs on R and B.
- Used as the memory endpoint in simulation and for the on-chip scratchpad.
- Read and write channels run as independent state machines that share one storage array.

Parameters:
- XLEN, 32, address width.
- AXILEN, 64, data width (8 byte lanes).
- MEM_DEPTH, 1024, number of AXILEN-bit words.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- awvalid in 1; awready out 1; awaddr in XLEN; awid in 4; awlen in 8; awsize in 3; awburst in 2.
- wvalid in 1; wready out 1; wdata in AXILEN; wstrb in 8; wlast in 1.
- bvalid out 1; bready in 1; bresp out 2; bid out 4.
- arvalid in 1; arready out 1; araddr in XLEN; arid in 4; arlen in 8; arsize in 3; arburst in 2.
- rvalid out 1; rready in 1; rdata out AXILEN; rresp out 2; rlast out 1; rid out 4.

Behaviour:
- Reset:
  - rvalid, bvalid, wready, rlast = 0; rdata = 0; rresp, bresp = 0; rid, bid = 0.
  - Both FSMs return to IDLE.
  - arready and awready = 0 while reset is high and 1 in the first cycle after reset.
  - The storage array is not cleared.
  - Reset mid-burst aborts the burst with no response.
- Word index: (addr - BASE_ADDR) >> 3. An address is in range iff BASE_ADDR <= addr < BASE_ADDR + 8*MEM_DEPTH.
- Read FSM (R_IDLE, R_DATA):
  - R_IDLE: arready = 1. On arvalid & arready, latch addr, id, len, size, burst, clear the beat counter and go to R_DATA.
  - rdata is loaded in the same edge from the array (read-before-write). rvalid = 1 from the next cycle, so AR-accept to first rvalid is 1 cycle.
  - R_DATA: rid = latched id. rlast = (beat counter == len).
  - rresp = 2'b00 in range. Out of range gives rresp = 2'b10 (SLVERR) and rdata = 0.
  - rvalid, rdata, rresp and rlast hold stable until rready.
  - On rvalid & rready with rlast: go to R_IDLE, rvalid = 0 next cycle. arready returns 1 in that next cycle, so there is no back-to-back AR acceptance in the R_DATA cycle.
  - On rvalid & rready without rlast: counter += 1. Next address = addr + (1 << size) for INCR and WRAP (WRAP is treated as INCR); unchanged for FIXED.
  - The next beat's data loads on the same edge, giving one beat per cycle under continuous rready.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: awready = 1. On handshake, latch the fields, clear the counter and the error flag, and go to W_DATA.
  - W_DATA: wready = 1. On wvalid & wready, if in range, write byte lane i when wstrb[i] is set; otherwise set the error flag and write nothing. Address advances per the read rules.
  - Burst ends when wlast = 1 or counter == len. If the two disagree, set the error flag and end the burst anyway. Then go to W_RESP.
  - W_RESP: bvalid = 1, bid = latched id, bresp = error ? 2'b10 : 2'b00. On bready, go to W_IDLE.
  - W data arriving before AW is not accepted (wready = 0 outside W_DATA).
- Simultaneous events:
  - Read and write may proceed in the same cycle.
  - Same-word collision: the read beat loaded on that edge returns the old data; the next read sees the new data.
- rdata is always the full aligned 64-bit word; lane selection for narrow sizes is left to the master.

Test Plan:
- Reset, then AW addr 0x8000_0010, id 1, len 0, size 3; W data 64'h1122334455667788, strb 8'hFF, wlast 1 -> bvalid 1 cycle after the W beat, bid 1, bresp 00. Then AR same addr, id 2 -> rvalid 1 cycle after AR, rdata 64'h1122334455667788, rid 2, rlast 1, rresp 00.
- Partial write strb 8'h0F, data 64'hAAAAAAAA_BBBBBBBB over 64'h1122334455667788 -> subsequent read 64'h11223344_BBBBBBBB.
- AR INCR len 3, size 3 at 0x8000_0000 with rready held high -> 4 consecutive beats from words 0..3, rlast only on the 4th. Repeat with rready toggling every cycle -> data holds stable while stalled.
- Read of 0x7FFF_FFF8 -> rresp 10, rdata 0, rlast 1. Write to 0x8000_2000 (MEM_DEPTH 1024) -> bresp 10 and the array is unchanged.
- AW len 1 with wlast asserted on the first beat -> burst ends, bresp 10. Reset asserted during R_DATA of a len 3 burst -> next cycle rvalid 0, and arready 1 after reset drops.
- Concurrent write and read to the same word in the same cycle -> the read returns the old value; a second read returns the new value.

Source files
------------

// File: rtl/lieat_axi_slave_sram.sv
// AXI4 slave backed by an on-chip SRAM: independent read/write FSMs over one array,
// INCR/FIXED bursts, byte-strobed writes, SLVERR outside the mapped window.
module lieat_axi_slave_sram #(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      AXILEN    = 64,
  parameter int unsigned      MEM_DEPTH = 1024,
  parameter logic [XLEN-1:0]  BASE_ADDR = 'h8000_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [XLEN-1:0]     awaddr,
  input  logic [3:0]          awid,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [AXILEN-1:0]   wdata,
  input  logic [AXILEN/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  output logic [3:0]          bid,
  input  logic                arvalid,
  output logic                arready,
  input  logic [XLEN-1:0]     araddr,
  input  logic [3:0]          arid,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [AXILEN-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic [3:0]          rid
);
  localparam int unsigned     LANES = AXILEN / 8;
  localparam int unsigned     OFFW  = $clog2(LANES);
  localparam int unsigned     IDXW  = $clog2(MEM_DEPTH);
  localparam logic [XLEN-1:0] SPAN  = XLEN'(MEM_DEPTH * LANES);

  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [AXILEN-1:0] mem [MEM_DEPTH];

  rstate_t         rstate;
  logic [XLEN-1:0] raddr, rd_addr;
  logic [7:0]      rlen, rcnt;
  logic [2:0]      rsize;
  logic [1:0]      rburst;

  wstate_t         wstate;
  logic [XLEN-1:0] waddr;
  logic [7:0]      wlen, wcnt;
  logic [2:0]      wsize;
  logic [1:0]      wburst;
  logic [3:0]      wid;
  logic            werr, w_err_next, w_end, w_fire;

  function automatic logic in_range(input logic [XLEN-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [XLEN-1:0] a);
    return IDXW'((a - BASE_ADDR) >> OFFW);
  endfunction

  function automatic logic [XLEN-1:0] next_addr(input logic [XLEN-1:0] a,
                                                input logic [2:0] size,
                                                input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (XLEN'(1) << size);
  endfunction

  assign arready = (rstate == R_IDLE) && !reset;
  assign awready = (wstate == W_IDLE) && !reset;
  assign wready  = (wstate == W_DATA);
  assign bvalid  = (wstate == W_RESP);

  // Address of the beat loaded on this edge: the AR address when idle, else the successor.
  always_comb begin
    rd_addr = (rstate == R_IDLE) ? araddr : next_addr(raddr, rsize, rburst);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rstate <= R_IDLE;
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      rdata  <= '0;
      rresp  <= '0;
      rid    <= '0;
      raddr  <= '0;
      rlen   <= '0;
      rcnt   <= '0;
      rsize  <= '0;
      rburst <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (arvalid && arready) begin
          raddr  <= araddr;
          rid    <= arid;
          rlen   <= arlen;
          rsize  <= arsize;
          rburst <= arburst;
          rcnt   <= '0;
          rdata  <= in_range(rd_addr) ? mem[word_idx(rd_addr)] : '0;
          rresp  <= in_range(rd_addr) ? 2'b00 : 2'b10;
          rlast  <= (arlen == 8'd0);
          rvalid <= 1'b1;
          rstate <= R_DATA;
        end
        R_DATA: if (rready) begin
          if (rlast) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            rstate <= R_IDLE;
          end else begin
            rcnt  <= rcnt + 8'd1;
            raddr <= rd_addr;
            rdata <= in_range(rd_addr) ? mem[word_idx(rd_addr)] : '0;
            rresp <= in_range(rd_addr) ? 2'b00 : 2'b10;
            rlast <= ((rcnt + 8'd1) == rlen);
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign w_fire     = (wstate == W_DATA) && wvalid;
  assign w_end      = wlast || (wcnt == wlen);
  assign w_err_next = werr || !in_range(waddr) || (wlast != (wcnt == wlen));

  always_ff @(posedge clock) begin
    if (reset) begin
      wstate <= W_IDLE;
      bresp  <= '0;
      bid    <= '0;
      waddr  <= '0;
      wid    <= '0;
      wlen   <= '0;
      wcnt   <= '0;
      wsize  <= '0;
      wburst <= '0;
      werr   <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: if (awvalid && awready) begin
          waddr  <= awaddr;
          wid    <= awid;
          wlen   <= awlen;
          wsize  <= awsize;
          wburst <= awburst;
          wcnt   <= '0;
          werr   <= 1'b0;
          wstate <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          wcnt  <= wcnt + 8'd1;
          waddr <= next_addr(waddr, wsize, wburst);
          werr  <= w_err_next;
          if (w_end) begin
            bid    <= wid;
            bresp  <= w_err_next ? 2'b10 : 2'b00;
            wstate <= W_RESP;
          end
        end
        W_RESP: if (bready) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Storage is never cleared; a same-edge read above still sees the pre-write word.
  always_ff @(posedge clock) begin
    if (!reset && w_fire && in_range(waddr)) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wstrb[i]) mem[word_idx(waddr)][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_lieat_axi_slave_sram.sv
// Directed bench for lieat_axi_slave_sram: cycle-exact handshakes with hand-computed data.
module tb_lieat_axi_slave_sram;
  logic        clock, reset;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int checks   = 0;
  int failures = 0;

  lieat_axi_slave_sram #(.XLEN(32), .AXILEN(64), .MEM_DEPTH(1024), .BASE_ADDR(32'h8000_0000)) dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst);
    awvalid = 1'b1; awaddr = a; awid = id; awlen = len; awsize = 3'd3; awburst = burst;
    step;
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s, input logic last);
    wvalid = 1'b1; wdata = d; wstrb = s; wlast = last;
    step;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_take;
    bready = 1'b1;
    step;
    bready = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst);
    arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = 3'd3; arburst = burst;
    step;
    arvalid = 1'b0;
  endtask

  task automatic wr1(input logic [31:0] a, input logic [3:0] id, input logic [63:0] d,
                     input logic [7:0] s, output logic [1:0] resp);
    aw_send(a, id, 8'd0, 2'b01);
    w_send(d, s, 1'b1);
    resp = bresp;
    b_take;
  endtask

  task automatic rd1(input logic [31:0] a, input logic [3:0] id, output logic v,
                     output logic [63:0] d, output logic [1:0] resp, output logic last,
                     output logic [3:0] rid_o);
    ar_send(a, id, 8'd0, 2'b01);
    v = rvalid; d = rdata; resp = rresp; last = rlast; rid_o = rid;
    rready = 1'b1;
    step;
    rready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step;
    step;
    checks++;
    if ({rvalid, bvalid, wready, rlast, rresp, bresp, rid, bid, arready, awready} !== 19'd0) begin
      failures++;
      $display("FAIL reset_ctrl got=%h exp=0", {rvalid, bvalid, wready, rlast, rresp, bresp, rid, bid, arready, awready});
    end
    checks++;
    if (rdata !== 64'd0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0", rdata);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({arready, awready} !== 2'b11) begin
      failures++; $display("FAIL reset_ready got=%b exp=11", {arready, awready});
    end
  endtask

  task automatic test_single;
    logic v, last; logic [63:0] d; logic [1:0] resp; logic [3:0] id;
    aw_send(32'h8000_0010, 4'd1, 8'd0, 2'b01);
    checks++;
    if ({wready, awready, bvalid} !== 3'b100) begin
      failures++; $display("FAIL aw_accept got=%b exp=100", {wready, awready, bvalid});
    end
    w_send(64'h1122334455667788, 8'hFF, 1'b1);
    checks++;
    if ({bvalid, bid, bresp, wready} !== {1'b1, 4'd1, 2'b00, 1'b0}) begin
      failures++; $display("FAIL single_b got=%h exp=%h", {bvalid, bid, bresp, wready}, {1'b1, 4'd1, 2'b00, 1'b0});
    end
    b_take;
    checks++;
    if (bvalid !== 1'b0) begin
      failures++; $display("FAIL b_clear got=%b exp=0", bvalid);
    end
    rd1(32'h8000_0010, 4'd2, v, d, resp, last, id);
    checks++;
    if ({v, d, resp, last, id} !== {1'b1, 64'h1122334455667788, 2'b00, 1'b1, 4'd2}) begin
      failures++; $display("FAIL single_r got=%h exp=%h", {v, d, resp, last, id}, {1'b1, 64'h1122334455667788, 2'b00, 1'b1, 4'd2});
    end
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      failures++; $display("FAIL r_done got=%b exp=01", {rvalid, arready});
    end
  endtask

  task automatic test_partial;
    logic v, last; logic [63:0] d; logic [1:0] resp; logic [3:0] id;
    wr1(32'h8000_0010, 4'd3, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, resp);
    checks++;
    if (resp !== 2'b00) begin
      failures++; $display("FAIL partial_b got=%b exp=00", resp);
    end
    rd1(32'h8000_0010, 4'd4, v, d, resp, last, id);
    checks++;
    if (d !== 64'h11223344_BBBBBBBB) begin
      failures++; $display("FAIL partial_r got=%h exp=%h", d, 64'h11223344_BBBBBBBB);
    end
  endtask

  task automatic test_burst_read;
    logic [1:0] resp;
    logic [63:0] w [4];
    for (int i = 0; i < 4; i++) begin
      w[i] = 64'hC0DE_0000_0000_0000 | 64'(i * 32'h0101 + 5);
      wr1(32'h8000_0000 + 32'(i * 8), 4'd0, w[i], 8'hFF, resp);
    end
    ar_send(32'h8000_0000, 4'd5, 8'd3, 2'b01);
    rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({rvalid, rdata, rlast, rid, rresp} !== {1'b1, w[b], (b == 3), 4'd5, 2'b00}) begin
        failures++; $display("FAIL burst_beat%0d got=%h exp=%h", b, {rvalid, rdata, rlast, rid, rresp}, {1'b1, w[b], (b == 3), 4'd5, 2'b00});
      end
      step;
    end
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin
      failures++; $display("FAIL burst_end got=%b exp=0", rvalid);
    end
    ar_send(32'h8000_0000, 4'd6, 8'd3, 2'b01);
    for (int b = 0; b < 4; b++) begin
      rready = 1'b0;
      step;
      checks++;
      if ({rvalid, rdata, rlast} !== {1'b1, w[b], (b == 3)}) begin
        failures++; $display("FAIL stall_beat%0d got=%h exp=%h", b, {rvalid, rdata, rlast}, {1'b1, w[b], (b == 3)});
      end
      rready = 1'b1;
      step;
    end
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin
      failures++; $display("FAIL stall_end got=%b exp=0", rvalid);
    end
  endtask

  task automatic test_fixed_burst;
    aw_send(32'h8000_0048, 4'd10, 8'd1, 2'b00);
    w_send(64'h0A0A0A0A_0A0A0A0A, 8'hFF, 1'b0);
    w_send(64'h0B0B0B0B_0B0B0B0B, 8'hFF, 1'b1);
    checks++;
    if ({bvalid, bresp, bid} !== {1'b1, 2'b00, 4'd10}) begin
      failures++; $display("FAIL fixed_b got=%h exp=%h", {bvalid, bresp, bid}, {1'b1, 2'b00, 4'd10});
    end
    b_take;
    ar_send(32'h8000_0048, 4'd11, 8'd1, 2'b00);
    rready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if ({rvalid, rdata, rlast} !== {1'b1, 64'h0B0B0B0B_0B0B0B0B, (b == 1)}) begin
        failures++; $display("FAIL fixed_beat%0d got=%h exp=%h", b, {rvalid, rdata, rlast}, {1'b1, 64'h0B0B0B0B_0B0B0B0B, (b == 1)});
      end
      step;
    end
    rready = 1'b0;
  endtask

  task automatic test_out_of_range;
    logic v, last; logic [63:0] d; logic [1:0] resp; logic [3:0] id;
    rd1(32'h7FFF_FFF8, 4'd12, v, d, resp, last, id);
    checks++;
    if ({v, d, resp, last} !== {1'b1, 64'd0, 2'b10, 1'b1}) begin
      failures++; $display("FAIL oor_read got=%h exp=%h", {v, d, resp, last}, {1'b1, 64'd0, 2'b10, 1'b1});
    end
    wr1(32'h8000_2000, 4'd13, 64'hDEADBEEF_DEADBEEF, 8'hFF, resp);
    checks++;
    if (resp !== 2'b10) begin
      failures++; $display("FAIL oor_bresp got=%b exp=10", resp);
    end
    rd1(32'h8000_0000, 4'd14, v, d, resp, last, id);
    checks++;
    if (d !== 64'hC0DE_0000_0000_0005) begin
      failures++; $display("FAIL oor_nowrite got=%h exp=%h", d, 64'hC0DE_0000_0000_0005);
    end
  endtask

  task automatic test_wlast_mismatch;
    aw_send(32'h8000_0040, 4'd15, 8'd1, 2'b01);
    w_send(64'h5555_5555_5555_5555, 8'hFF, 1'b1);
    checks++;
    if ({bvalid, bresp, wready} !== {1'b1, 2'b10, 1'b0}) begin
      failures++; $display("FAIL wlast_early got=%b exp=%b", {bvalid, bresp, wready}, {1'b1, 2'b10, 1'b0});
    end
    b_take;
    checks++;
    if ({wready, awready} !== 2'b01) begin
      failures++; $display("FAIL w_idle got=%b exp=01", {wready, awready});
    end
  endtask

  task automatic test_reset_mid_burst;
    ar_send(32'h8000_0000, 4'd9, 8'd3, 2'b01);
    checks++;
    if (rvalid !== 1'b1) begin
      failures++; $display("FAIL midrst_pre got=%b exp=1", rvalid);
    end
    reset = 1'b1;
    step;
    checks++;
    if ({rvalid, rlast, arready} !== 3'b000) begin
      failures++; $display("FAIL midrst_abort got=%b exp=000", {rvalid, rlast, arready});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({arready, awready, rvalid} !== 3'b110) begin
      failures++; $display("FAIL midrst_after got=%b exp=110", {arready, awready, rvalid});
    end
  endtask

  task automatic test_collision;
    logic v, last; logic [63:0] d; logic [1:0] resp; logic [3:0] id;
    wr1(32'h8000_0030, 4'd1, 64'h0101_0101_0101_0101, 8'hFF, resp);
    aw_send(32'h8000_0030, 4'd7, 8'd0, 2'b01);
    wvalid = 1'b1; wdata = 64'h7777_6666_5555_4444; wstrb = 8'hFF; wlast = 1'b1;
    arvalid = 1'b1; araddr = 32'h8000_0030; arid = 4'd8; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01;
    step;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    checks++;
    if ({rvalid, rdata, rid} !== {1'b1, 64'h0101_0101_0101_0101, 4'd8}) begin
      failures++; $display("FAIL collide_old got=%h exp=%h", {rvalid, rdata, rid}, {1'b1, 64'h0101_0101_0101_0101, 4'd8});
    end
    checks++;
    if ({bvalid, bresp, bid} !== {1'b1, 2'b00, 4'd7}) begin
      failures++; $display("FAIL collide_b got=%h exp=%h", {bvalid, bresp, bid}, {1'b1, 2'b00, 4'd7});
    end
    rready = 1'b1; bready = 1'b1;
    step;
    rready = 1'b0; bready = 1'b0;
    rd1(32'h8000_0030, 4'd2, v, d, resp, last, id);
    checks++;
    if (d !== 64'h7777_6666_5555_4444) begin
      failures++; $display("FAIL collide_new got=%h exp=%h", d, 64'h7777_6666_5555_4444);
    end
  endtask

  initial begin
    reset = 1'b1;
    awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
    rready = 1'b0;
    test_reset;
    test_single;
    test_partial;
    test_burst_read;
    test_fixed_burst;
    test_out_of_range;
    test_wlast_mismatch;
    test_reset_mid_burst;
    test_collision;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
